mod_exp_ctrl: RTL
=================

# mod_exp_ctrl

Modular-exponentiation sequencer for the RSA datapath: computes result = base^exponent mod modulus by driving the MontgomeryMultiplier through its go/done handshake. It sits directly upstream of the multiplier, issuing each Montgomery product in turn. The block owns domain conversion, a fixed-length square-and-multiply loop and result capture; it holds no arithmetic of its own.

## Interface
- BITS, 16, operand/modulus width; must match the multiplier.
- EXP_BITS, 16, exponent width; the loop length.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base  in  BITS  message/ciphertext, must be < modulus
- exponent  in  EXP_BITS  e or d
- modulus  in  BITS  odd modulus
- r2  in  BITS  R^2 mod modulus, R = 2^BITS, precomputed by software
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse; result/err valid
- err  out  1  set with done when the modulus is even
- result  out  BITS  held until the next accepted start
- mm_a, mm_b, mm_m  out  BITS  multiplier operands
- mm_go  out  1  multiplier request
- mm_done  in  1  multiplier completion
- mm_s  in  BITS  multiplier product A·B·R⁻¹ mod M, fully reduced

## Operation
- On start in IDLE: latch base, exponent, modulus, r2 into internal registers. Later changes to the input ports have no effect until the next start.
- If modulus[0]==0: go to FINISH with err=1, result=0 and no multiplier traffic.
- Otherwise, sequence the following Montgomery products (MM):
  - TO_MONT_X: xbar = MM(base, r2).
  - TO_MONT_ONE: acc = MM(1, r2), which yields R mod M.
  - LOOP: for i = EXP_BITS-1 down to 0:
    - SQUARE: acc = MM(acc, acc).
    - If exponent[i] is set, MULT: acc = MM(acc, xbar).
  - FROM_MONT: result = MM(acc, 1).
  - FINISH: then return to IDLE.
- The loop never skips leading zeros. Every call performs exactly EXP_BITS squarings.
- Total MM count = 3 + EXP_BITS + popcount(exponent).
- Each MM state has three phases:
  - ISSUE: mm_go=1, operands driven.
  - WAIT: hold mm_go and operands stable until mm_done=1, then capture mm_s.
  - RELEASE: mm_go=0 for exactly one cycle.
- mm_m always carries the latched modulus.
- mm_done is ignored outside WAIT.
- start is ignored while busy.
- Exponent 0 yields result = 1 (M > 1).

## Timing
- Reset values: busy=0, done=0, err=0, result=0, mm_go=0, mm_a=mm_b=mm_m=0, state IDLE, loop counter 0.
- Reset asserted mid-operation aborts immediately to these values. No done pulse is produced.
- start accepted in cycle t → busy=1 and mm_go=1 in cycle t+1.
- For a multiplier latency of L_k cycles (mm_go rising to mm_done), MM k occupies L_k+1 cycles plus one RELEASE cycle. The next mm_go rises right after RELEASE.
- done pulses the cycle after the final RELEASE. busy falls in the same cycle. err and result are valid in that cycle.
- Even-modulus path: done at t+2, with zero mm_go pulses.
- mm_done arriving in the same cycle as ISSUE counts as completion: capture and move to RELEASE.

## Structure
- Shared package rsa_pkg holds:
  - BITS and EXP_BITS defaults;
  - the state enum (IDLE, TO_MONT_X, TO_MONT_ONE, SQUARE, MULT, FROM_MONT, FINISH);
  - the phase enum (ISSUE, WAIT, RELEASE).
- One natural sub-module, mm_issue: owns the ISSUE/WAIT/RELEASE phase, mm_go and product capture. It reports a one-cycle "product ready" pulse to the main FSM.
- The loop index is a down-counter of width clog2(EXP_BITS).

## Test plan
Benches use BITS=16, EXP_BITS=16 and the real MontgomeryMultiplier.
- base=2, exponent=3, modulus=11, r2=4 → result=8, err=0, exactly 21 mm_go pulses.
- base=65, exponent=17, modulus=3233, r2=1155 → result=2790. Then base=2790, exponent=2753 → result=65.
- base=7, exponent=0, modulus=11, r2=4 → result=1, 19 mm_go pulses.
- modulus=10 → done at t+2 with err=1, result=0, mm_go never asserted.
- Reset during SQUARE:
  - all outputs return to zero and done is not pulsed;
  - a following start with base=2, exponent=10, modulus=11 → result=1.
- start pulsed while busy and input ports changed mid-run → ignored; result matches the latched operands.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation path: default widths and the
// sequencer/handshake state encodings.
package rsa_pkg;

  localparam int BITS_DEF     = 16;
  localparam int EXP_BITS_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    TO_MONT_X,
    TO_MONT_ONE,
    SQUARE,
    MULT,
    FROM_MONT,
    FINISH
  } state_t;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    RELEASE
  } phase_t;

endpackage

// File: rtl/mod_exp_ctrl_mm_issue.sv
// Go/done handshake with the Montgomery multiplier: raises mm_go, captures the
// product on mm_done, then drops mm_go for one cycle and flags the product ready.
module mm_issue
  import rsa_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            mm_done,
  input  logic [BITS-1:0] mm_s,
  output logic            mm_go,
  output logic            prod_ready,
  output logic [BITS-1:0] prod
);

  phase_t          phase_reg, phase_next;
  logic [BITS-1:0] prod_reg;
  logic            capture;

  // Completion is accepted in ISSUE as well as WAIT, so a zero-latency multiplier works.
  assign capture = req && (phase_reg != RELEASE) && mm_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= ISSUE;
      prod_reg  <= '0;
    end else begin
      phase_reg <= phase_next;
      if (capture) prod_reg <= mm_s;
    end
  end

  always_comb begin
    phase_next = phase_reg;
    if (req) begin
      case (phase_reg)
        ISSUE, WAIT: phase_next = mm_done ? RELEASE : WAIT;
        RELEASE:     phase_next = ISSUE;
        default:     phase_next = ISSUE;
      endcase
    end
  end

  always_comb begin
    mm_go      = req && ((phase_reg == ISSUE) || (phase_reg == WAIT));
    prod_ready = req && (phase_reg == RELEASE);
    prod       = prod_reg;
  end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation sequencer: converts into the Montgomery domain, runs a
// fixed-length left-to-right square-and-multiply loop, and converts back.
module mod_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int BITS     = BITS_DEF,
  parameter int EXP_BITS = EXP_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BITS-1:0]     base,
  input  logic [EXP_BITS-1:0] exponent,
  input  logic [BITS-1:0]     modulus,
  input  logic [BITS-1:0]     r2,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [BITS-1:0]     result,
  output logic [BITS-1:0]     mm_a,
  output logic [BITS-1:0]     mm_b,
  output logic [BITS-1:0]     mm_m,
  output logic                mm_go,
  input  logic                mm_done,
  input  logic [BITS-1:0]     mm_s
);

  localparam int CNT_W = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam logic [BITS-1:0] ONE = BITS'(1);

  state_t              state_reg, state_next;
  logic [BITS-1:0]     base_reg, mod_reg, r2_reg, xbar_reg, acc_reg, result_reg;
  logic [EXP_BITS-1:0] exp_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                err_reg;
  logic                mm_req, prod_ready;
  logic [BITS-1:0]     prod;
  logic                in_mm_state;

  assign in_mm_state = (state_reg == TO_MONT_X) || (state_reg == TO_MONT_ONE) ||
                       (state_reg == SQUARE) || (state_reg == MULT) ||
                       (state_reg == FROM_MONT);
  // An even modulus never reaches the multiplier.
  assign mm_req = in_mm_state && mod_reg[0];

  mm_issue #(.BITS(BITS)) u_issue (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (mm_req),
    .mm_done    (mm_done),
    .mm_s       (mm_s),
    .mm_go      (mm_go),
    .prod_ready (prod_ready),
    .prod       (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      base_reg   <= '0;
      exp_reg    <= '0;
      mod_reg    <= '0;
      r2_reg     <= '0;
      xbar_reg   <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (start) begin
          base_reg   <= base;
          exp_reg    <= exponent;
          mod_reg    <= modulus;
          r2_reg     <= r2;
          result_reg <= '0;
          err_reg    <= 1'b0;
          cnt_reg    <= '0;
        end
        TO_MONT_X: begin
          if (!mod_reg[0]) err_reg <= 1'b1;
          else if (prod_ready) xbar_reg <= prod;
        end
        TO_MONT_ONE: if (prod_ready) begin
          acc_reg <= prod;
          cnt_reg <= CNT_W'(EXP_BITS - 1);
        end
        SQUARE: if (prod_ready) begin
          acc_reg <= prod;
          if (!exp_reg[cnt_reg] && (cnt_reg != '0)) cnt_reg <= cnt_reg - 1'b1;
        end
        MULT: if (prod_ready) begin
          acc_reg <= prod;
          if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
        end
        FROM_MONT: if (prod_ready) result_reg <= prod;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:        if (start) state_next = TO_MONT_X;
      TO_MONT_X: begin
        if (!mod_reg[0])     state_next = FINISH;
        else if (prod_ready) state_next = TO_MONT_ONE;
      end
      TO_MONT_ONE: if (prod_ready) state_next = SQUARE;
      SQUARE: if (prod_ready) begin
        if (exp_reg[cnt_reg])      state_next = MULT;
        else if (cnt_reg == '0)    state_next = FROM_MONT;
        else                       state_next = SQUARE;
      end
      MULT: if (prod_ready) state_next = (cnt_reg == '0) ? FROM_MONT : SQUARE;
      FROM_MONT:   if (prod_ready) state_next = FINISH;
      FINISH:      state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_reg != IDLE) && (state_reg != FINISH);
    done   = (state_reg == FINISH);
    err    = err_reg;
    result = result_reg;
    mm_m   = mod_reg;
    mm_a   = '0;
    mm_b   = '0;
    case (state_reg)
      TO_MONT_X:   begin mm_a = base_reg; mm_b = r2_reg;   end
      TO_MONT_ONE: begin mm_a = ONE;      mm_b = r2_reg;   end
      SQUARE:      begin mm_a = acc_reg;  mm_b = acc_reg;  end
      MULT:        begin mm_a = acc_reg;  mm_b = xbar_reg; end
      FROM_MONT:   begin mm_a = acc_reg;  mm_b = ONE;      end
      default: ;
    endcase
  end

endmodule
